// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the output buffer SRAM.
// Latency: n/a (package only).
// Backpressure: n/a.
package sram_pkg;

   // Drain engine states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } drain_state_t;

   // True when an AW-bit address can reach every one of DEPTH entries
   function automatic bit aw_fits(input int aw, input int depth);
      return (depth >= 1) && (aw >= 1) && (aw < 31) && (depth <= (1 << aw));
   endfunction

   // Minimum index width for a DEPTH-entry array (at least one bit)
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_core.sv
// DW x DEPTH storage with per-entry written flags; unwritten or out-of-range reads return 0.
// Latency: read data registered, valid one cycle after rd_en; writes land at the clock edge.
// Backpressure: none; rd_q holds its value until the next rd_en.
module sram_core
   import sram_pkg::*;
#(
   parameter int DW     = 16,
   parameter int DEPTH  = 10,
   parameter int AW     = 6,
   parameter int BYPASS = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 we,
   input  logic [AW-1:0]        wr_addr,
   input  logic signed [DW-1:0] d,
   input  logic                 rd_en,
   input  logic [AW-1:0]        rd_addr,
   output logic signed [DW-1:0] rd_q
);

   localparam int            IW   = idx_width(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic signed [DW-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]     r_flag;
   logic signed [DW-1:0] r_rd_q;

   logic                 w_wr_ok;
   logic                 w_rd_inb;
   logic                 w_hit;
   logic [IW-1:0]        w_wr_idx;
   logic [IW-1:0]        w_rd_idx;
   logic signed [DW-1:0] w_rd_dat;

   assign w_wr_ok  = we && (wr_addr <= LAST);
   assign w_rd_inb = (rd_addr <= LAST);
   assign w_wr_idx = wr_addr[IW-1:0];
   assign w_rd_idx = rd_addr[IW-1:0];
   // Same-cycle forwarding only exists when BYPASS is set and the write is legal
   assign w_hit    = (BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr);

   // Read mux: forwarded write data, stored word if written, otherwise zero
   always_comb begin
      w_rd_dat = '0;
      if (w_rd_inb) begin
         if (w_hit)
            w_rd_dat = d;
         else if (r_flag[w_rd_idx])
            w_rd_dat = r_mem[w_rd_idx];
      end
   end

   // Storage array is deliberately not reset; the flags gate visibility instead
   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[w_wr_idx] <= d;
   end

   // Written flags: clr wipes them, a same-cycle write re-sets its own flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flag <= '0;
      end else begin
         if (clr)
            r_flag <= '0;
         if (w_wr_ok)
            r_flag[w_wr_idx] <= 1'b1;
      end
   end

   // Registered read port; holds between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rd_q <= '0;
      else if (rd_en)
         r_rd_q <= w_rd_dat;
   end

   assign rd_q = r_rd_q;

endmodule

// File: rtl/sram_output_buf.sv
// Layer output buffer: one write port, registered random read, and a drain engine streaming all entries.
// Latency: random read 1 cycle; drain one word per two cycles with q_ready high.
// Backpressure: in drain mode q/q_valid/q_last hold while q_ready is low; random reads have no handshake.
module sram_output_buf
   import sram_pkg::*;
#(
   parameter int DW     = 16,
   parameter int DEPTH  = 10,
   parameter int AW     = 6,
   parameter int BYPASS = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 we,
   input  logic [AW-1:0]        wr_addr,
   input  logic signed [DW-1:0] d,
   input  logic                 re,
   input  logic [AW-1:0]        rd_addr,
   input  logic                 drain_start,
   input  logic                 q_ready,
   output logic signed [DW-1:0] q,
   output logic                 q_valid,
   output logic                 q_last,
   output logic                 busy,
   output logic                 err_oob
);

   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
   localparam bit            AW_OK = aw_fits(AW, DEPTH);

   generate
      if (!AW_OK) begin : g_bad_aw
         $error("sram_output_buf: AW too small for DEPTH");
      end
   endgenerate

   drain_state_t  r_state;
   logic [AW-1:0] r_ptr;
   logic          r_q_valid;
   logic          r_q_last;
   logic          r_err_oob;

   drain_state_t  w_nxt_state;
   logic [AW-1:0] w_nxt_ptr;
   logic          w_nxt_valid;
   logic          w_nxt_last;
   logic          w_rd_en;
   logic          w_rd_rand;
   logic [AW-1:0] w_rd_addr;
   logic          w_err_set;

   sram_core #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .BYPASS (BYPASS)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .we      (we),
      .wr_addr (wr_addr),
      .d       (d),
      .rd_en   (w_rd_en),
      .rd_addr (w_rd_addr),
      .rd_q    (q)
   );

   // Drain FSM state, pointer and output flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_q_valid <= 1'b0;
         r_q_last  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_ptr     <= w_nxt_ptr;
         r_q_valid <= w_nxt_valid;
         r_q_last  <= w_nxt_last;
      end
   end

   // Next state and read-port arbitration; drain_start beats a same-cycle re
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_ptr;
      w_nxt_valid = r_q_valid;
      w_nxt_last  = r_q_last;
      w_rd_en     = 1'b0;
      w_rd_rand   = 1'b0;
      w_rd_addr   = rd_addr;
      case (r_state)
         ST_IDLE: begin
            w_nxt_valid = 1'b0;
            w_nxt_last  = 1'b0;
            if (drain_start) begin
               w_nxt_state = ST_FETCH;
               w_nxt_ptr   = '0;
            end else if (re) begin
               w_rd_en     = 1'b1;
               w_rd_rand   = 1'b1;
               w_nxt_valid = 1'b1;
            end
         end
         ST_FETCH: begin
            w_rd_en     = 1'b1;
            w_rd_addr   = r_ptr;
            w_nxt_valid = 1'b1;
            w_nxt_last  = (r_ptr == LAST);
            w_nxt_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (q_ready) begin
               w_nxt_valid = 1'b0;
               if (r_q_last) begin
                  w_nxt_last  = 1'b0;
                  w_nxt_ptr   = '0;
                  w_nxt_state = ST_IDLE;
               end else begin
                  w_nxt_ptr   = r_ptr + AW'(1);
                  w_nxt_state = ST_FETCH;
               end
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_ptr   = '0;
            w_nxt_valid = 1'b0;
            w_nxt_last  = 1'b0;
         end
      endcase
   end

   // Only accepted random reads can flag a bad read address; drain pointer is always legal
   assign w_err_set = (we && (wr_addr > LAST)) || (w_rd_rand && (rd_addr > LAST));

   // Sticky out-of-range flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err_oob <= 1'b0;
      else if (w_err_set)
         r_err_oob <= 1'b1;
   end

   assign q_valid = r_q_valid;
   assign q_last  = r_q_last;
   assign busy    = (r_state != ST_IDLE);
   assign err_oob = r_err_oob;

endmodule

// File: tb/tb_sram_output_buf.sv
// Directed bench for sram_output_buf: one instance with BYPASS=0, one with BYPASS=1, shared inputs.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: drain stall exercised by holding q_ready low.
module tb_sram_output_buf;

   localparam int DW = 16;
   localparam int DEPTH = 10;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] d = '0;
   logic          re = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          drain_start = 1'b0;
   logic          q_ready = 1'b0;

   logic [DW-1:0] q0, q1;
   logic          vld0, vld1, last0, last1, busy0, busy1, err0, err1;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_mem [DEPTH];

   always #5 clk = ~clk;

   sram_output_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(0)) u_dut0 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wr_addr(wr_addr), .d(d),
      .re(re), .rd_addr(rd_addr), .drain_start(drain_start), .q_ready(q_ready),
      .q(q0), .q_valid(vld0), .q_last(last0), .busy(busy0), .err_oob(err0)
   );

   sram_output_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(1)) u_dut1 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wr_addr(wr_addr), .d(d),
      .re(re), .rd_addr(rd_addr), .drain_start(drain_start), .q_ready(q_ready),
      .q(q1), .q_valid(vld1), .q_last(last1), .busy(busy1), .err_oob(err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full drain of the BYPASS=0 instance against exp_mem; optional stall and stray re
   task automatic do_drain(input int stall_at, input int re_at);
      q_ready = 1'b1;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      chk("drain_busy_start", 32'(busy0), 32'd1);
      chk("drain_fetch_vld", 32'(vld0), 32'd0);
      for (int w = 0; w < DEPTH; w++) begin
         tick();
         chk("drain_word", 32'(q0), 32'(exp_mem[w]));
         chk("drain_vld", 32'(vld0), 32'd1);
         chk("drain_last", 32'(last0), (w == DEPTH - 1) ? 32'd1 : 32'd0);
         if (w == stall_at) begin
            q_ready = 1'b0;
            we = 1'b1;
            wr_addr = 6'd8;
            d = 16'd55;
            exp_mem[8] = 16'd55;
            for (int k = 0; k < 5; k++) begin
               tick();
               we = 1'b0;
               chk("stall_word", 32'(q0), 32'(exp_mem[w]));
               chk("stall_vld", 32'(vld0), 32'd1);
            end
            q_ready = 1'b1;
         end
         if (w == re_at) begin
            re = 1'b1;
            rd_addr = 6'd5;
         end
         tick();
         re = 1'b0;
         chk("accept_vld", 32'(vld0), 32'd0);
         chk("accept_last", 32'(last0), 32'd0);
         chk("accept_busy", 32'(busy0), (w == DEPTH - 1) ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      chk("rst_q", 32'(q0), 32'd0);
      chk("rst_vld", 32'(vld0), 32'd0);
      chk("rst_last", 32'(last0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      rst = 1'b0;
      tick();

      // Unwritten read returns zero with a one-cycle valid pulse
      re = 1'b1; rd_addr = 6'd3;
      tick();
      re = 1'b0;
      chk("rd_unwritten_q", 32'(q0), 32'd0);
      chk("rd_unwritten_vld", 32'(vld0), 32'd1);
      tick();
      chk("rd_vld_pulse", 32'(vld0), 32'd0);

      // Negative value round trip
      we = 1'b1; wr_addr = 6'd3; d = 16'hFFFB;
      tick();
      we = 1'b0;
      re = 1'b1; rd_addr = 6'd3;
      tick();
      re = 1'b0;
      chk("rd_neg_q", 32'(q0), 32'h0000FFFB);
      chk("rd_neg_vld", 32'(vld0), 32'd1);

      // Out-of-range write and read
      we = 1'b1; wr_addr = 6'd12; d = 16'd100;
      tick();
      we = 1'b0;
      chk("oob_wr_err", 32'(err0), 32'd1);
      re = 1'b1; rd_addr = 6'd12;
      tick();
      re = 1'b0;
      chk("oob_rd_q", 32'(q0), 32'd0);
      chk("oob_rd_vld", 32'(vld0), 32'd1);
      tick();
      chk("oob_err_sticky", 32'(err0), 32'd1);

      // Same-cycle write/read of one address
      we = 1'b1; wr_addr = 6'd2; d = 16'd4;
      tick();
      wr_addr = 6'd2; d = 16'd7; re = 1'b1; rd_addr = 6'd2;
      tick();
      we = 1'b0; re = 1'b0;
      chk("bypass0_q", 32'(q0), 32'd4);
      chk("bypass1_q", 32'(q1), 32'd7);
      chk("bypass1_vld", 32'(vld1), 32'd1);

      // Fill 0..9 and drain with q_ready high; stray re during word 6
      for (int i = 0; i < DEPTH; i++) begin
         we = 1'b1; wr_addr = AW'(i); d = DW'(i);
         exp_mem[i] = DW'(i);
         tick();
      end
      we = 1'b0;
      do_drain(-1, 6);

      // Drain with a 5-cycle stall on word 4 and a write to entry 8 during it
      do_drain(4, -1);

      // Async reset while holding word 6
      q_ready = 1'b1;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      tick();
      for (int w = 1; w <= 6; w++) begin
         tick();
         tick();
      end
      chk("pre_rst_q", 32'(q0), 32'd6);
      chk("pre_rst_vld", 32'(vld0), 32'd1);
      q_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy0), 32'd0);
      chk("mid_rst_vld", 32'(vld0), 32'd0);
      chk("mid_rst_q", 32'(q0), 32'd0);
      chk("mid_rst_err", 32'(err0), 32'd0);
      chk("mid_rst_busy1", 32'(busy1), 32'd0);
      chk("mid_rst_last1", 32'(last1), 32'd0);
      chk("mid_rst_err1", 32'(err1), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Refill, clear with a same-cycle write to entry 5, then drain
      for (int i = 0; i < DEPTH; i++) begin
         we = 1'b1; wr_addr = AW'(i); d = DW'(i + 20);
         tick();
      end
      clr = 1'b1; we = 1'b1; wr_addr = 6'd5; d = 16'd77;
      tick();
      clr = 1'b0; we = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_mem[5] = 16'd77;
      do_drain(-1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
